oled_spi_tx: RTL

Tick-paced SPI mode-0 byte transmitter that drives the OLED display's serial bus. It consumes the single-cycle `max_tick` strobe from the upstream modulus-M counter (M=15 → one tick every 15 clocks) as its bit-rate enable, so SCLK runs at tick rate / 2. It accepts one byte plus a data/command flag per `start` and returns a one-cycle `done_tick`. The display frame controller uses `done_tick` to sequence the next byte.

---
 rtl/oled_spi_tx_if.sv | 26 ++
 rtl/oled_spi_tx.sv | 79 +++++++
 2 files changed

// File: rtl/oled_spi_tx_if.sv
// Byte-level request/response and SPI pin bundle for oled_spi_tx.
// The master side is the frame controller; the slave side is the transmitter.
interface oled_spi_tx_if #(
  parameter int DW = 8
);
  logic          tick;
  logic          start;
  logic [DW-1:0] din;
  logic          dc_in;
  logic          ready;
  logic          done_tick;
  logic          sclk;
  logic          mosi;
  logic          cs_n;
  logic          dc;

  modport master (
    output tick, start, din, dc_in,
    input  ready, done_tick, sclk, mosi, cs_n, dc
  );

  modport slave (
    input  tick, start, din, dc_in,
    output ready, done_tick, sclk, mosi, cs_n, dc
  );
endinterface

// File: rtl/oled_spi_tx.sv
// Tick-paced SPI mode-0 byte transmitter for the OLED serial bus, MSB first,
// with a trailing chip-select hold phase and a one-clock completion strobe.
module oled_spi_tx #(
  parameter int DW = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  oled_spi_tx_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_t;

  state_t        state;
  logic [DW-1:0] shreg;
  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] shifted;

  assign shifted = {shreg[DW-2:0], 1'b0};

  // Every pin is a flop so the bus never sees a combinational path from inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      bus.sclk      <= 1'b0;
      bus.mosi      <= 1'b0;
      bus.cs_n      <= 1'b1;
      bus.dc        <= 1'b0;
      bus.ready     <= 1'b1;
      bus.done_tick <= 1'b0;
    end else begin
      bus.done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg     <= bus.din;
            bus.dc    <= bus.dc_in;
            bit_cnt   <= '0;
            bus.mosi  <= bus.din[DW-1];
            bus.cs_n  <= 1'b0;
            bus.ready <= 1'b0;
            state     <= LOW;
          end
        end
        LOW: begin
          if (bus.tick) begin
            bus.sclk <= 1'b1;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (bus.tick) begin
            bus.sclk <= 1'b0;
            // Exit is by compare so the counter never wraps past the last bit.
            if (bit_cnt == CW'(DW - 1)) begin
              state <= HOLD;
            end else begin
              shreg    <= shifted;
              bus.mosi <= shifted[DW-1];
              bit_cnt  <= bit_cnt + 1'b1;
              state    <= LOW;
            end
          end
        end
        HOLD: begin
          if (bus.tick) begin
            bus.cs_n      <= 1'b1;
            bus.mosi      <= 1'b0;
            bus.ready     <= 1'b1;
            bus.done_tick <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
